// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and legal WIDTH range.
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;
endpackage

// File: rtl/half_adder.sv
// Combinational one-bit half adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder composed from two half adders; the single arithmetic cell of serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

  assign carry = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell reused over WIDTH cycles, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via inverted b and forced carry-in).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt;
  logic               sub_i;
  logic               fa_sum, fa_carry;
  logic               last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  assign last_bit = (cnt == CNT_W'(WIDTH-1));

  full_adder u_fa (
    .a(a_sr[0]), .b(b_sr[0]), .cin(carry_q), .sum(fa_sum), .carry(fa_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last_bit) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_sr    <= a;
          b_sr    <= b ^ {WIDTH{sub_i}};
          carry_q <= sub_i | cin;
          cnt     <= '0;
        end
        RUN: begin
          // LSB-first: sum bits enter at the MSB and reach their place after WIDTH shifts
          res_sr  <= {fa_sum, res_sr[WIDTH-1:1]};
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_q <= fa_carry;
          if (!last_bit) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum  = res_sr;
  assign cout = carry_q;
endmodule
